// File: rtl/pe_regfile_ctx.sv
// Processing-element register file with neighbour capture, FU writeback, operand bypass
// and per-channel transmit; a zeroing sweep runs after every reset before normal operation.
module pe_regfile_ctx #(
  parameter int DW    = 32,
  parameter int DEPTH = 64,
  parameter int NIN   = 4
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic [NIN*DW-1:0]        in_data,
  input  logic [NIN-1:0]           in_sel,
  input  logic [$clog2(DEPTH)-1:0] put_in_addr,
  input  logic                     ld,
  input  logic                     ld_write,
  input  logic [DW-1:0]            out2reg,
  input  logic                     write_back,
  input  logic [$clog2(DEPTH)-1:0] put_out_addr,
  input  logic [$clog2(DEPTH)-1:0] rd_addr1,
  input  logic [$clog2(DEPTH)-1:0] rd_addr2,
  input  logic [NIN-1:0]           byp_sel1,
  input  logic [NIN-1:0]           byp_sel2,
  output logic [DW-1:0]            reg_out1,
  output logic [DW-1:0]            reg_out2,
  output logic                     rd_invalid1,
  output logic                     rd_invalid2,
  input  logic [$clog2(DEPTH)-1:0] send_addr,
  input  logic [NIN-1:0]           out_en,
  output logic [NIN*DW-1:0]        out_data,
  output logic                     busy,
  output logic                     conflict,
  output logic [7:0]               conflict_cnt
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     sweep_cnt_q, sweep_cnt_d;
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic              conflict_q, conflict_d;
  logic [7:0]        conflict_cnt_q, conflict_cnt_d;
  logic [DW-1:0]     mem_q [DEPTH];

  logic run, cap_fire, wb_fire, collide, cap_eff;

  function automatic logic is_onehot(input logic [NIN-1:0] v);
    return (v != '0) && ((v & (v - NIN'(1))) == '0);
  endfunction

  // OR-mux of the flagged channels; callers only use it with a one-hot select
  function automatic logic [DW-1:0] pick_chan(input logic [NIN*DW-1:0] d,
                                              input logic [NIN-1:0] s);
    logic [DW-1:0] r;
    r = '0;
    for (int k = 0; k < NIN; k++)
      if (s[k]) r = r | d[k*DW +: DW];
    return r;
  endfunction

  always_comb begin
    run      = (state_q == ST_RUN);
    cap_fire = run && is_onehot(in_sel) && (!ld || ld_write);
    wb_fire  = run && write_back;
    collide  = cap_fire && wb_fire && (put_in_addr == put_out_addr);
    // writeback owns the entry on a same-address collision
    cap_eff  = cap_fire && !collide;

    state_d        = state_q;
    sweep_cnt_d    = sweep_cnt_q;
    valid_d        = valid_q;
    conflict_d     = collide;
    conflict_cnt_d = conflict_cnt_q;

    if (!run) begin
      sweep_cnt_d = sweep_cnt_q + AW'(1);
      if (sweep_cnt_q == AW'(DEPTH - 1)) state_d = ST_RUN;
    end
    if (cap_eff) valid_d[put_in_addr]  = 1'b1;
    if (wb_fire) valid_d[put_out_addr] = 1'b1;
    if (collide && conflict_cnt_q != 8'hFF) conflict_cnt_d = conflict_cnt_q + 8'd1;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q        <= ST_INIT;
      sweep_cnt_q    <= '0;
      valid_q        <= '0;
      conflict_q     <= 1'b0;
      conflict_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      sweep_cnt_q    <= sweep_cnt_d;
      valid_q        <= valid_d;
      conflict_q     <= conflict_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  // Storage is not reset; the sweep zeroes it instead
  always_ff @(posedge CLK) begin
    if (RST_N) begin
      if (!run) begin
        mem_q[sweep_cnt_q] <= '0;
      end else begin
        if (cap_eff) mem_q[put_in_addr]  <= pick_chan(in_data, in_sel);
        if (wb_fire) mem_q[put_out_addr] <= out2reg;
      end
    end
  end

  always_comb begin
    reg_out1    = '0;
    reg_out2    = '0;
    rd_invalid1 = 1'b0;
    rd_invalid2 = 1'b0;
    out_data    = '0;
    if (run) begin
      if (byp_sel1 == '0)          reg_out1 = mem_q[rd_addr1];
      else if (is_onehot(byp_sel1)) reg_out1 = pick_chan(in_data, byp_sel1);
      if (byp_sel2 == '0)          reg_out2 = mem_q[rd_addr2];
      else if (is_onehot(byp_sel2)) reg_out2 = pick_chan(in_data, byp_sel2);
      rd_invalid1 = (byp_sel1 == '0) && !valid_q[rd_addr1];
      rd_invalid2 = (byp_sel2 == '0) && !valid_q[rd_addr2];
      for (int k = 0; k < NIN; k++)
        if (out_en[k]) out_data[k*DW +: DW] = mem_q[send_addr];
    end
  end

  assign busy         = (state_q == ST_INIT);
  assign conflict     = conflict_q;
  assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_pe_regfile_ctx.sv
// Directed bench for pe_regfile_ctx at default parameters (DW=32, DEPTH=64, NIN=4).
module tb_pe_regfile_ctx;
  logic         CLK = 1'b0;
  logic         RST_N;
  logic [127:0] in_data;
  logic [3:0]   in_sel;
  logic [5:0]   put_in_addr;
  logic         ld, ld_write;
  logic [31:0]  out2reg;
  logic         write_back;
  logic [5:0]   put_out_addr;
  logic [5:0]   rd_addr1, rd_addr2;
  logic [3:0]   byp_sel1, byp_sel2;
  logic [31:0]  reg_out1, reg_out2;
  logic         rd_invalid1, rd_invalid2;
  logic [5:0]   send_addr;
  logic [3:0]   out_en;
  logic [127:0] out_data;
  logic         busy, conflict;
  logic [7:0]   conflict_cnt;

  int errors = 0;
  int checks = 0;
  int n;

  always #5 CLK = ~CLK;

  pe_regfile_ctx dut (
    .CLK(CLK), .RST_N(RST_N), .in_data(in_data), .in_sel(in_sel),
    .put_in_addr(put_in_addr), .ld(ld), .ld_write(ld_write),
    .out2reg(out2reg), .write_back(write_back), .put_out_addr(put_out_addr),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .byp_sel1(byp_sel1), .byp_sel2(byp_sel2),
    .reg_out1(reg_out1), .reg_out2(reg_out2),
    .rd_invalid1(rd_invalid1), .rd_invalid2(rd_invalid2),
    .send_addr(send_addr), .out_en(out_en), .out_data(out_data),
    .busy(busy), .conflict(conflict), .conflict_cnt(conflict_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST_N = 1'b0; in_data = '0; in_sel = '0; put_in_addr = '0; ld = 1'b0; ld_write = 1'b0;
    out2reg = '0; write_back = 1'b0; put_out_addr = '0; rd_addr1 = '0; rd_addr2 = '0;
    byp_sel1 = '0; byp_sel2 = '0; send_addr = '0; out_en = '0;

    // Reset state; outputs forced quiet during INIT
    step();
    out_en = 4'hF; byp_sel1 = 4'b1000; in_data[96 +: 32] = 32'hA5A5A5A5;
    #1;
    chk("rst_busy", busy, 1);
    chk("rst_conflict", conflict, 0);
    chk("rst_cnt", conflict_cnt, 0);
    chk("init_reg_out1", reg_out1, 0);
    chk("init_rd_invalid1", rd_invalid1, 0);
    chk("init_out_data_lo", out_data[31:0], 0);
    chk("init_out_data_hi", out_data[127:96], 0);

    // Release with writes requested during the sweep; they must be dropped
    RST_N = 1'b1; byp_sel1 = '0; out_en = '0;
    in_data[31:0] = 32'h77; in_sel = 4'b0001; put_in_addr = 6'd3;
    write_back = 1'b1; out2reg = 32'h88; put_out_addr = 6'd4;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      n++;
      if (n == 1) begin in_sel = '0; write_back = 1'b0; end
      if (!busy) break;
    end
    chk("sweep_len", n, 64);
    rd_addr1 = 6'd63; rd_addr2 = 6'd3; #1;
    chk("e63_val", reg_out1, 0);
    chk("e63_invalid", rd_invalid1, 1);
    chk("init_cap_dropped", rd_invalid2, 1);
    rd_addr2 = 6'd4; #1;
    chk("init_wb_dropped", rd_invalid2, 1);

    // Capture from channel 2; same-cycle read sees the old contents
    in_data[64 +: 32] = 32'hDEADBEEF; in_sel = 4'b0100; put_in_addr = 6'd5; rd_addr1 = 6'd5; #1;
    chk("no_fwd_val", reg_out1, 0);
    chk("no_fwd_inv", rd_invalid1, 1);
    step();
    in_sel = '0; #1;
    chk("cap_val", reg_out1, 32'hDEADBEEF);
    chk("cap_inv", rd_invalid1, 0);

    // Load gating blocks, then permits
    in_data[64 +: 32] = 32'h11111111; in_sel = 4'b0100; put_in_addr = 6'd6; ld = 1'b1; ld_write = 1'b0;
    step();
    in_sel = '0; rd_addr1 = 6'd6; #1;
    chk("ld_block_inv", rd_invalid1, 1);
    in_sel = 4'b0100; ld_write = 1'b1;
    step();
    in_sel = '0; ld = 1'b0; ld_write = 1'b0; #1;
    chk("ld_permit_val", reg_out1, 32'h11111111);
    // Multi-hot select is ignored
    in_sel = 4'b0101; put_in_addr = 6'd7;
    step();
    in_sel = '0; rd_addr1 = 6'd7; #1;
    chk("multihot_no_write", rd_invalid1, 1);

    // Same-address collision: writeback wins
    in_data[31:0] = 32'h1; in_sel = 4'b0001; put_in_addr = 6'd9;
    out2reg = 32'h2; write_back = 1'b1; put_out_addr = 6'd9; #1;
    chk("pre_conflict", conflict, 0);
    step();
    in_sel = '0; write_back = 1'b0; rd_addr1 = 6'd9; #1;
    chk("conflict_pulse", conflict, 1);
    chk("conflict_cnt1", conflict_cnt, 1);
    chk("conflict_winner", reg_out1, 32'h2);

    // Distinct-address writes both land
    in_data[31:0] = 32'hAAAA; in_sel = 4'b0001; put_in_addr = 6'd10;
    out2reg = 32'hBBBB; write_back = 1'b1; put_out_addr = 6'd11;
    step();
    in_sel = '0; write_back = 1'b0; rd_addr1 = 6'd10; rd_addr2 = 6'd11; #1;
    chk("conflict_drop", conflict, 0);
    chk("dual_cap", reg_out1, 32'hAAAA);
    chk("dual_wb", reg_out2, 32'hBBBB);
    chk("dual_cnt_hold", conflict_cnt, 1);

    // Transmit entry 5 on channels 1 and 3
    out2reg = 32'h1234; write_back = 1'b1; put_out_addr = 6'd5;
    step();
    write_back = 1'b0; send_addr = 6'd5; out_en = 4'b1010; #1;
    chk("tx_ch0", out_data[31:0], 0);
    chk("tx_ch1", out_data[63:32], 32'h1234);
    chk("tx_ch2", out_data[95:64], 0);
    chk("tx_ch3", out_data[127:96], 32'h1234);
    out_en = '0;

    // Bypass of bus channel, then a multi-hot bypass
    rd_addr2 = 6'd63; byp_sel2 = 4'b1000; in_data[96 +: 32] = 32'hA5A5A5A5; #1;
    chk("byp_val", reg_out2, 32'hA5A5A5A5);
    chk("byp_inv", rd_invalid2, 0);
    byp_sel2 = 4'b1001; #1;
    chk("byp_multi_val", reg_out2, 0);
    chk("byp_multi_inv", rd_invalid2, 0);
    byp_sel2 = '0;

    // Saturation after 300 consecutive collisions
    in_data[31:0] = 32'h1; in_sel = 4'b0001; put_in_addr = 6'd9;
    out2reg = 32'h2; write_back = 1'b1; put_out_addr = 6'd9;
    repeat (300) step();
    chk("cnt_sat", conflict_cnt, 255);
    chk("conflict_held", conflict, 1);
    in_sel = '0; write_back = 1'b0;
    step();
    chk("conflict_clear", conflict, 0);

    // Reset from RUN, then again mid-sweep at sweep_cnt=30
    RST_N = 1'b0;
    step();
    chk("rerst_busy", busy, 1);
    chk("rerst_cnt", conflict_cnt, 0);
    RST_N = 1'b1;
    repeat (30) step();
    chk("midsweep_busy", busy, 1);
    RST_N = 1'b0;
    step();
    RST_N = 1'b1;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      n++;
      if (!busy) break;
    end
    chk("resweep_len", n, 64);
    rd_addr1 = 6'd5; rd_addr2 = 6'd9; #1;
    chk("valid_clr5", rd_invalid1, 1);
    chk("valid_clr9", rd_invalid2, 1);
    chk("zeroed5", reg_out1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pe_regfile_ctx.md
PE_REGFILE_CTX -- requirements
Module: pe_regfile_ctx

Interface
REQ-001 SHALL have parameter DW, default 32: data width of every datapath port and register entry.
REQ-002 SHALL have parameter DEPTH, default 64: number of register entries, a power of 2 and at least 2; AW = log2(DEPTH).
REQ-003 SHALL have parameter NIN, default 4: number of neighbour channels, where channel k occupies bits [k*DW +: DW] and defaults to 0=edge2, 1=edge4, 2=edge1, 3=bus.
REQ-004 SHALL have ports CLK (input, 1, sole clock, posedge) and RST_N (input, 1, synchronous active-low reset).
REQ-005 SHALL have in_data (input, NIN*DW, neighbour data) and in_sel (input, NIN, one-hot channel to capture).
REQ-006 SHALL have put_in_addr (input, AW, capture address), ld (input, 1, load-gating mode) and ld_write (input, 1, write permit when ld=1).
REQ-007 SHALL have out2reg (input, DW, FU result), write_back (input, 1, FU write enable) and put_out_addr (input, AW, FU write address).
REQ-008 SHALL have rd_addr1 and rd_addr2 (input, AW each, FU operand addresses) and byp_sel1 and byp_sel2 (input, NIN each, one-hot neighbour bypass, where all-zero selects the register file).
REQ-009 SHALL have reg_out1 and reg_out2 (output, DW each, FU operands) and rd_invalid1 and rd_invalid2 (output, 1 each, operand read from a never-written entry).
REQ-010 SHALL have send_addr (input, AW, entry to transmit), out_en (input, NIN, per-channel transmit enable) and out_data (output, NIN*DW, neighbour outputs).
REQ-011 SHALL have busy (output, 1, init sweep active), conflict (output, 1, registered same-address write collision pulse) and conflict_cnt (output, 8, saturating collision count).

Function
REQ-012 SHALL implement a two-state FSM, INIT and RUN, with busy=1 exactly while in INIT.
REQ-013 In INIT, each cycle SHALL write 0 to entry sweep_cnt and increment sweep_cnt, moving to RUN on the cycle after the write to entry DEPTH-1 (DEPTH cycles total).
REQ-014 In INIT, all capture and writeback writes SHALL be ignored, reg_out1/2 and out_data SHALL be 0, and rd_invalid1/2 SHALL be 0.
REQ-015 Capture write SHALL occur at posedge when the FSM is in RUN, in_sel has exactly one bit set, and (ld=0 or ld_write=1).
- Data written: the selected channel of in_data, at put_in_addr.
- in_sel all-zero or with multiple bits set: no write.
REQ-016 Writeback SHALL occur at posedge when the FSM is in RUN and write_back=1, writing out2reg at put_out_addr.
REQ-017 If capture and writeback both fire with put_in_addr == put_out_addr, writeback SHALL win and conflict SHALL be 1 for exactly the following cycle.
REQ-018 On each conflict, conflict_cnt SHALL increment by 1, saturating at 255.
REQ-019 Each entry SHALL have a valid bit, set on any write to that entry and cleared only by reset.
REQ-020 reg_out[n] SHALL be combinational, selected by byp_sel[n]:
- one-hot: the selected in_data channel;
- all-zero: entry rd_addr[n];
- multiple bits set: 0.
REQ-021 Reads SHALL return pre-edge contents, with no write-to-read forwarding in the same cycle.
REQ-022 rd_invalid[n] SHALL equal (FSM in RUN) AND (byp_sel[n]==0) AND (valid bit of entry rd_addr[n] is 0).
REQ-023 out_data channel k SHALL equal entry send_addr when out_en[k]=1, else 0, with multiple channels allowed simultaneously.
REQ-024 Two distinct-address writes in one cycle SHALL both complete.

Reset
REQ-025 When RST_N=0 at posedge, the block SHALL enter INIT with sweep_cnt=0, all valid bits=0, conflict=0 and conflict_cnt=0.
REQ-026 Reset asserted mid-sweep or in RUN SHALL restart the full DEPTH-cycle sweep.
REQ-027 busy SHALL be 1 from the first posedge with RST_N=0 until the sweep completes.

Verification
REQ-028 Release reset with DEPTH=64 -> busy=1 for 64 cycles then 0; entry 63 reads 0 with rd_invalid=1.
REQ-029 In RUN: in_sel=4'b0100, in_data ch2=32'hDEADBEEF, put_in_addr=5, ld=0 -> next cycle, rd_addr1=5 gives reg_out1=32'hDEADBEEF and rd_invalid1=0; the same stimulus with ld=1, ld_write=0 gives no write.
REQ-030 Capture to addr 9 (32'h1) and writeback to addr 9 (32'h2) in the same cycle -> entry 9 = 32'h2, conflict=1 for one cycle, conflict_cnt=1; 300 consecutive conflicts -> conflict_cnt=255.
REQ-031 byp_sel2=4'b1000 with bus channel=32'hA5A5A5A5 -> reg_out2=32'hA5A5A5A5 combinationally, rd_invalid2=0; byp_sel2=4'b1001 -> reg_out2=0.
REQ-032 send_addr=5 holding 32'h1234, out_en=4'b1010 -> channels 1 and 3 = 32'h1234, channels 0 and 2 = 0.
REQ-033 RST_N=0 for one cycle mid-sweep (sweep_cnt=30) -> sweep restarts at 0, busy stays 1 for a further 64 cycles, and all valid bits clear.
